// File: rtl/gcn_agg_pkg.sv
// GCN aggregation shared types and element adder.
// Define GCN_AGG_SAT_EN for saturating adds; default wraps.
package gcn_agg_pkg;

   localparam int ROW_COLS = 3;
   localparam int ELEM_W   = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_EDGE,
      S_SELF,
      S_DRAIN,
      S_DONE
   } agg_state_e;

   typedef logic [ROW_COLS-1:0][ELEM_W-1:0] row_t;

   // Operands arrive sign-extended; result is valid in its low w bits.
   function automatic logic [31:0] add_elem(
      input logic [31:0] a,
      input logic [31:0] b,
      input int          w
   );
      logic signed [31:0] s;
`ifdef GCN_AGG_SAT_EN
      logic signed [31:0] lim;
`endif
      s = signed'(a) + signed'(b);
`ifdef GCN_AGG_SAT_EN
      lim = 32'sd1 <<< (w - 1);
      if (s >= lim)
         s = lim - 32'sd1;
      else if (s < -lim)
         s = -lim;
`else
      s = (s <<< (32 - w)) >>> (32 - w);
`endif
      return s;
   endfunction

endpackage

// File: rtl/gcn_agg_if.sv
// Memory-side and control bus of the GCN aggregation engine.
// Engine uses the slave view; memories/controller use master.
interface gcn_agg_if #(
   parameter int NODE_W         = 3,
   parameter int COO_BW         = 3,
   parameter int WEIGHT_COLS    = 3,
   parameter int DOT_PROD_WIDTH = 16
) ();

   logic                                        done_trans;
   logic [COO_BW-1:0]                           coo_address;
   logic [NODE_W-1:0]                           coo_src;
   logic [NODE_W-1:0]                           coo_dst;
   logic [NODE_W-1:0]                           read_row;
   logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]  FM_WM_Row;
   logic [NODE_W-1:0]                           read_row_adj;
   logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]  fm_wm_adj_out;
   logic                                        busy;
   logic                                        done_comb;
   logic                                        err_addr;

   modport master (
      output done_trans, coo_src, coo_dst, FM_WM_Row, read_row_adj,
      input  coo_address, read_row, fm_wm_adj_out,
      input  busy, done_comb, err_addr
   );

   modport slave (
      input  done_trans, coo_src, coo_dst, FM_WM_Row, read_row_adj,
      output coo_address, read_row, fm_wm_adj_out,
      output busy, done_comb, err_addr
   );

endinterface

// File: rtl/gcn_agg_accum_bank.sv
// Accumulator row bank: one-cycle clear, RMW accumulate port,
// registered read port returning zeros past the last node.
module gcn_agg_accum_bank
   import gcn_agg_pkg::*;
#(
   parameter int NUM_OF_NODES   = 6,
   parameter int WEIGHT_COLS    = 3,
   parameter int DOT_PROD_WIDTH = 16,
   parameter int NODE_W         = $clog2(NUM_OF_NODES)
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       clr,
   input  logic                                       acc_en,
   input  logic [NODE_W-1:0]                          acc_idx,
   input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] acc_row,
   input  logic [NODE_W-1:0]                          rd_idx,
   output logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] rd_row
);

   typedef logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] bank_row_t;

   bank_row_t acc [NUM_OF_NODES];
   bank_row_t sum_row;

   always_comb begin
      sum_row = '0;
      for (int c = 0; c < WEIGHT_COLS; c++) begin
         sum_row[c] = DOT_PROD_WIDTH'(add_elem(
            32'(signed'(acc[acc_idx][c])),
            32'(signed'(acc_row[c])),
            DOT_PROD_WIDTH));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_OF_NODES; i++)
            acc[i] <= '0;
         rd_row <= '0;
      end else begin
         if (clr) begin
            for (int i = 0; i < NUM_OF_NODES; i++)
               acc[i] <= '0;
         end else if (acc_en) begin
            acc[acc_idx] <= sum_row;
         end
         rd_row <= (int'(rd_idx) < NUM_OF_NODES) ? acc[rd_idx] : '0;
      end
   end

endmodule

// File: rtl/gcn_aggregation_engine.sv
// GCN aggregation A*(F*W): streams COO edges (plus optional
// self-loops) through a 2-stage pipeline into the accumulator bank.
module gcn_aggregation_engine
   import gcn_agg_pkg::*;
#(
   parameter int NUM_OF_NODES    = 6,
   parameter int COO_NUM_OF_COLS = 6,
   parameter int WEIGHT_COLS     = 3,
   parameter int DOT_PROD_WIDTH  = 16,
   parameter int ADD_SELF_LOOP   = 0,
   parameter int NODE_W          = $clog2(NUM_OF_NODES),
   parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
   input logic      clk,
   input logic      reset,
   gcn_agg_if.slave bus
);

   localparam logic [COO_BW-1:0] LAST_EDGE = COO_BW'(COO_NUM_OF_COLS - 1);
   localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_OF_NODES - 1);

   agg_state_e        state_q;
   agg_state_e        state_d;
   logic [COO_BW-1:0] edge_cnt;
   logic [NODE_W-1:0] node_cnt;
   logic              drain_cnt;
   logic              err_q;
   logic              p0_valid;
   logic              p0_self;
   logic [NODE_W-1:0] p0_node;
   logic              p1_valid;
   logic [NODE_W-1:0] p1_dst;
   logic [NODE_W-1:0] src;
   logic [NODE_W-1:0] dst;
   logic              bad;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (bus.done_trans) state_d = S_CLEAR;
         S_CLEAR: state_d = S_EDGE;
         S_EDGE:
            if (edge_cnt == LAST_EDGE)
               state_d = (ADD_SELF_LOOP != 0) ? S_SELF : S_DRAIN;
         S_SELF:  if (node_cnt == LAST_NODE) state_d = S_DRAIN;
         S_DRAIN: if (drain_cnt) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Stage 1: self-loop entries replace the COO memory output.
   assign src = p0_self ? p0_node : bus.coo_src;
   assign dst = p0_self ? p0_node : bus.coo_dst;
   assign bad = (int'(src) >= NUM_OF_NODES) ||
                (int'(dst) >= NUM_OF_NODES);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edge_cnt  <= '0;
         node_cnt  <= '0;
         drain_cnt <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (state_q == S_CLEAR) begin
            edge_cnt  <= '0;
            node_cnt  <= '0;
            drain_cnt <= 1'b0;
            err_q     <= 1'b0;
         end
         if (state_q == S_EDGE && edge_cnt != LAST_EDGE)
            edge_cnt <= edge_cnt + 1'b1;
         if (state_q == S_SELF && node_cnt != LAST_NODE)
            node_cnt <= node_cnt + 1'b1;
         if (state_q == S_DRAIN)
            drain_cnt <= ~drain_cnt;
         if (p0_valid && bad)
            err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p0_valid <= 1'b0;
         p0_self  <= 1'b0;
         p0_node  <= '0;
         p1_valid <= 1'b0;
         p1_dst   <= '0;
      end else begin
         p0_valid <= (state_q == S_EDGE) || (state_q == S_SELF);
         p0_self  <= (state_q == S_SELF);
         p0_node  <= node_cnt;
         p1_valid <= p0_valid && !bad;
         p1_dst   <= dst;
      end
   end

   assign bus.coo_address = edge_cnt;
   assign bus.read_row    = p0_valid ? src : '0;
   assign bus.busy        = (state_q == S_CLEAR) || (state_q == S_EDGE) ||
                            (state_q == S_SELF)  || (state_q == S_DRAIN);
   assign bus.done_comb   = (state_q == S_DONE);
   assign bus.err_addr    = err_q;

   gcn_agg_accum_bank #(
      .NUM_OF_NODES   (NUM_OF_NODES),
      .WEIGHT_COLS    (WEIGHT_COLS),
      .DOT_PROD_WIDTH (DOT_PROD_WIDTH),
      .NODE_W         (NODE_W)
   ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .clr     (state_q == S_CLEAR),
      .acc_en  (p1_valid),
      .acc_idx (p1_dst),
      .acc_row (bus.FM_WM_Row),
      .rd_idx  (bus.read_row_adj),
      .rd_row  (bus.fm_wm_adj_out)
   );

endmodule

// File: tb/tb_gcn_aggregation_engine.sv
// Directed bench for gcn_aggregation_engine: one plain and one
// self-loop instance share behavioural COO and FM_WM memories.
module tb_gcn_aggregation_engine;
   import gcn_agg_pkg::*;

   localparam int N  = 6;
   localparam int E  = 6;
   localparam int NW = 3;
   localparam int CB = 3;

   typedef struct {
      int   unit;
      int   row;
      row_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_chk;
   int   n_fail;

   logic [NW-1:0] src_m [8];
   logic [NW-1:0] dst_m [8];
   row_t          fm_m  [8];

   always #5 clk = ~clk;

   gcn_agg_if #(.NODE_W(NW), .COO_BW(CB), .WEIGHT_COLS(ROW_COLS),
                .DOT_PROD_WIDTH(ELEM_W)) b0 ();
   gcn_agg_if #(.NODE_W(NW), .COO_BW(CB), .WEIGHT_COLS(ROW_COLS),
                .DOT_PROD_WIDTH(ELEM_W)) b1 ();

   gcn_aggregation_engine #(
      .NUM_OF_NODES(N), .COO_NUM_OF_COLS(E), .WEIGHT_COLS(ROW_COLS),
      .DOT_PROD_WIDTH(ELEM_W), .ADD_SELF_LOOP(0)
   ) u0 (.clk(clk), .reset(reset), .bus(b0));

   gcn_aggregation_engine #(
      .NUM_OF_NODES(N), .COO_NUM_OF_COLS(E), .WEIGHT_COLS(ROW_COLS),
      .DOT_PROD_WIDTH(ELEM_W), .ADD_SELF_LOOP(1)
   ) u1 (.clk(clk), .reset(reset), .bus(b1));

   // One-cycle-latency memories
   always @(posedge clk) begin
      b0.coo_src   <= src_m[b0.coo_address];
      b0.coo_dst   <= dst_m[b0.coo_address];
      b0.FM_WM_Row <= fm_m[b0.read_row];
      b1.coo_src   <= src_m[b1.coo_address];
      b1.coo_dst   <= dst_m[b1.coo_address];
      b1.FM_WM_Row <= fm_m[b1.read_row];
   end

   function automatic row_t mk(input int a, input int b, input int c);
      row_t r;
      r[0] = 16'(a);
      r[1] = 16'(b);
      r[2] = 16'(c);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic load_base();
      int s [6] = '{0, 2, 3, 5, 1, 4};
      int d [6] = '{1, 1, 4, 0, 2, 4};
      for (int r = 0; r < 8; r++) begin
         fm_m[r]  = mk(r + 1, 2 * (r + 1), 3 * (r + 1));
         src_m[r] = '0;
         dst_m[r] = '0;
      end
      for (int i = 0; i < 6; i++) begin
         src_m[i] = 3'(s[i]);
         dst_m[i] = 3'(d[i]);
      end
   endtask

   function automatic logic dn(input int u);
      return (u == 0) ? b0.done_comb : b1.done_comb;
   endfunction

   task automatic set_dt(input int u, input logic v);
      if (u == 0) b0.done_trans = v;
      else        b1.done_trans = v;
   endtask

   // k = cycle index relative to the start edge T when done_comb seen
   task automatic run(input int u, input int pulse_at, output int k,
                      output logic busy_clr);
      @(negedge clk);
      set_dt(u, 1'b1);
      @(negedge clk);
      set_dt(u, 1'b0);
      k = 1;
      busy_clr = (u == 0) ? b0.busy : b1.busy;
      while (!dn(u) && k < 200) begin
         set_dt(u, k == pulse_at);
         @(negedge clk);
         k++;
      end
      set_dt(u, 1'b0);
   endtask

   task automatic rd(input int u, input int r, output row_t v);
      @(negedge clk);
      if (u == 0) b0.read_row_adj = 3'(r);
      else        b1.read_row_adj = 3'(r);
      @(negedge clk);
      v = (u == 0) ? b0.fm_wm_adj_out : b1.fm_wm_adj_out;
   endtask

   initial begin
      vec_t vt [13];
      row_t v;
      int   k;
      logic bz;
      int   seen;

      n_chk  = 0;
      n_fail = 0;
      b0.done_trans   = 1'b0;
      b1.done_trans   = 1'b0;
      b0.read_row_adj = '0;
      b1.read_row_adj = '0;
      load_base();

      vt[0]  = '{0, 0, mk(6, 12, 18)};
      vt[1]  = '{0, 1, mk(4, 8, 12)};
      vt[2]  = '{0, 2, mk(2, 4, 6)};
      vt[3]  = '{0, 3, mk(0, 0, 0)};
      vt[4]  = '{0, 4, mk(9, 18, 27)};
      vt[5]  = '{0, 5, mk(0, 0, 0)};
      vt[6]  = '{0, 7, mk(0, 0, 0)};
      vt[7]  = '{1, 0, mk(7, 14, 21)};
      vt[8]  = '{1, 1, mk(6, 12, 18)};
      vt[9]  = '{1, 2, mk(5, 10, 15)};
      vt[10] = '{1, 3, mk(4, 8, 12)};
      vt[11] = '{1, 4, mk(14, 28, 42)};
      vt[12] = '{1, 5, mk(6, 12, 18)};

      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_coo_address", 64'(b0.coo_address), 64'd0);
      chk("rst_read_row", 64'(b0.read_row), 64'd0);
      chk("rst_adj_out", 64'(b0.fm_wm_adj_out), 64'd0);
      chk("rst_busy", 64'(b0.busy), 64'd0);
      chk("rst_done", 64'(b0.done_comb), 64'd0);
      chk("rst_err", 64'(b0.err_addr), 64'd0);
      reset = 1'b0;

      run(0, -1, k, bz);
      chk("done_at_plain", 64'(k), 64'd10);
      chk("busy_in_clear", 64'(bz), 64'd1);
      chk("busy_in_done", 64'(b0.busy), 64'd0);
      @(negedge clk);
      chk("done_one_cycle", 64'(b0.done_comb), 64'd0);

      run(1, -1, k, bz);
      chk("done_at_self", 64'(k), 64'd16);

      for (int i = 0; i < 13; i++) begin
         rd(vt[i].unit, vt[i].row, v);
         chk($sformatf("row_u%0d_r%0d", vt[i].unit, vt[i].row),
             64'(v), 64'(vt[i].exp));
      end

      // Start pulse inside EDGE must not restart the run
      run(0, 4, k, bz);
      chk("ignore_done_at", 64'(k), 64'd10);
      rd(0, 1, v);
      chk("ignore_row1", 64'(v), 64'(mk(4, 8, 12)));
      rd(0, 4, v);
      chk("ignore_row4", 64'(v), 64'(mk(9, 18, 27)));

      dst_m[2] = 3'd7;
      run(0, -1, k, bz);
      chk("err_done_at", 64'(k), 64'd10);
      chk("err_set", 64'(b0.err_addr), 64'd1);
      rd(0, 4, v);
      chk("err_row4", 64'(v), 64'(mk(5, 10, 15)));
      rd(0, 1, v);
      chk("err_row1", 64'(v), 64'(mk(4, 8, 12)));
      rd(0, 3, v);
      chk("err_row3", 64'(v), 64'(mk(0, 0, 0)));
      dst_m[2] = 3'd4;
      run(0, -1, k, bz);
      chk("err_cleared", 64'(b0.err_addr), 64'd0);

      fm_m[3] = mk(16'h7000, 1, 16'h8000);
      for (int i = 0; i < 6; i++) begin
         src_m[i] = (i < 2) ? 3'd3 : 3'd1;
         dst_m[i] = (i < 2) ? 3'd0 : 3'd2;
      end
      run(0, -1, k, bz);
      rd(0, 0, v);
`ifdef GCN_AGG_SAT_EN
      chk("sat_row0", 64'(v), 64'(mk(16'h7FFF, 2, 16'h8000)));
`else
      chk("wrap_row0", 64'(v), 64'(mk(16'hE000, 2, 16'h0000)));
`endif
      rd(0, 2, v);
      chk("sat_row2", 64'(v), 64'(mk(8, 16, 24)));
      load_base();

      // Reset in cycle T+5 aborts the run
      @(negedge clk);
      set_dt(0, 1'b1);
      @(negedge clk);
      set_dt(0, 1'b0);
      repeat (4) @(negedge clk);
      chk("busy_before_abort", 64'(b0.busy), 64'd1);
      reset = 1'b1;
      #1;
      chk("abort_busy", 64'(b0.busy), 64'd0);
      chk("abort_coo_address", 64'(b0.coo_address), 64'd0);
      chk("abort_read_row", 64'(b0.read_row), 64'd0);
      chk("abort_adj_out", 64'(b0.fm_wm_adj_out), 64'd0);
      chk("abort_err", 64'(b0.err_addr), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (b0.done_comb) seen++;
      end
      chk("abort_no_done", 64'(seen), 64'd0);
      rd(0, 1, v);
      chk("abort_row1_cleared", 64'(v), 64'd0);
      run(0, -1, k, bz);
      chk("rerun_done_at", 64'(k), 64'd10);
      rd(0, 1, v);
      chk("rerun_row1", 64'(v), 64'(mk(4, 8, 12)));
      rd(0, 4, v);
      chk("rerun_row4", 64'(v), 64'(mk(9, 18, 27)));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gcn_aggregation_engine.md
# gcn_aggregation_engine

Parametrised GCN aggregation stage (A·(F·W)) that sits between the FM×WM product memory and the layer's argmax/output stage. On `done_trans` it clears an internal accumulator bank, then streams the COO edge list at one edge per cycle. For each edge it adds the source node's FM_WM row into the destination node's accumulator row. Optionally it adds self-loops, then raises `done_comb`. Results are read back row-by-row through a registered read port.

## Interface
Parameters:
- `NUM_OF_NODES`, 6: node count; accumulator bank depth.
- `COO_NUM_OF_COLS`, 6: edge count in COO memory.
- `WEIGHT_COLS`, 3: elements per row.
- `DOT_PROD_WIDTH`, 16: signed element and accumulator width.
- `ADD_SELF_LOOP`, 0: 1 runs an extra pass adding each node's own row (A+I).
- `NODE_W`, `$clog2(NUM_OF_NODES)`: node index width (derived).
- `COO_BW`, `$clog2(COO_NUM_OF_COLS)`: edge address width (derived).

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `done_trans` in 1: start pulse; sampled only in IDLE.
- `coo_address` out COO_BW: edge address to COO memory (1-cycle read latency).
- `coo_src`, `coo_dst` in NODE_W each: edge endpoints, valid the cycle after `coo_address`.
- `read_row` out NODE_W: row address to FM_WM memory (1-cycle read latency).
- `FM_WM_Row` in WEIGHT_COLS×DOT_PROD_WIDTH: source row, valid the cycle after `read_row`.
- `read_row_adj` in NODE_W: result read address.
- `fm_wm_adj_out` out WEIGHT_COLS×DOT_PROD_WIDTH: registered result row.
- `busy` out 1: high from CLEAR through DRAIN.
- `done_comb` out 1: one-cycle completion pulse.
- `err_addr` out 1: sticky flag; an out-of-range node index was seen.

## Operation
- FSM states: IDLE → CLEAR → EDGE → [SELF if ADD_SELF_LOOP] → DRAIN → DONE → IDLE.
- IDLE: waits for `done_trans`. A start pulse in any other state is ignored.
- CLEAR: zeroes all accumulator rows in one cycle, clears `err_addr`, and sets the edge counter to 0.
- EDGE:
  - `coo_address` counts 0..COO_NUM_OF_COLS-1, one per cycle; no wrap.
  - Stage 1 drives `read_row = coo_src` combinationally and registers `coo_dst`.
  - Stage 2 adds `FM_WM_Row` elementwise into `acc[dst]`.
- SELF: a node counter runs 0..NUM_OF_NODES-1. It feeds the same pipeline with src = dst = counter.
- DRAIN: two cycles to flush stages 1–2.
- DONE: `done_comb` = 1 for one cycle, then the FSM returns to IDLE.
- Hazards:
  - Accumulate reads the register bank directly, so back-to-back edges with the same dst need no stall or forwarding.
  - Edges are processed strictly in address order.
- Out-of-range index (src or dst ≥ NUM_OF_NODES): that edge's accumulate is suppressed and `err_addr` is set. Processing continues.
- Arithmetic is signed, DOT_PROD_WIDTH wide; overflow behaviour is set per Configuration.
- Read port: `fm_wm_adj_out` ← `acc[read_row_adj]` at each clock, in any state. While `busy`, it returns partial sums.
- `read_row_adj` ≥ NUM_OF_NODES returns all zeros.

## Timing
- `done_trans` sampled high at edge T (IDLE):
  - T+1: CLEAR.
  - T+2 .. T+E+1: EDGE, where E = COO_NUM_OF_COLS.
  - Next N cycles: SELF, where N = NUM_OF_NODES if ADD_SELF_LOOP else 0.
  - Next 2 cycles: DRAIN.
  - `done_comb` high in cycle T+E+N+4.
- Edge e's accumulate commits at the end of cycle T+e+4.
- Read latency: 1 cycle from `read_row_adj` to `fm_wm_adj_out`.
- Reset values:
  - `coo_address`, `read_row`, `fm_wm_adj_out`: 0.
  - `busy`, `done_comb`, `err_addr`: 0.
  - All accumulators: 0; FSM: IDLE.
- `reset` mid-run aborts immediately to IDLE with all state cleared. No `done_comb` is produced.

## Configuration
- `GCN_AGG_SAT_EN` defined: each element add saturates to [−2^(W−1), 2^(W−1)−1].
- Undefined: two's-complement wraparound.

## Structure
- Package `gcn_agg_pkg`:
  - `agg_state_e` enum.
  - `row_t` typedef: WEIGHT_COLS×DOT_PROD_WIDTH.
  - `add_elem` function, with the saturation branch under `GCN_AGG_SAT_EN`.
- Sub-module `gcn_agg_accum_bank`:
  - Register array, clear, RMW accumulate port and registered read port.
  - The FSM, counters and pipeline stay in the top module.

## Test plan
- FM row r = {r+1, 2(r+1), 3(r+1)}; edges (0→1), (2→1), (3→4), (5→0), (1→2), (4→4):
  - Row 1 = {4, 8, 12}.
  - Row 4 = {9, 18, 27}.
  - Row 3 = {0, 0, 0}.
  - `done_comb` pulses at T+10.
- ADD_SELF_LOOP=1, same stimulus:
  - Row 3 = {4, 8, 12}.
  - Row 1 = {6, 12, 18}.
  - `done_comb` pulses at T+16.
- Two edges into node 0, each carrying element 0x7000:
  - With `GCN_AGG_SAT_EN`: 0x7FFF.
  - Without: 0xE000.
- Edge (2→7) with NUM_OF_NODES=6: `err_addr` = 1, other rows unaffected, `err_addr` clears on the next start.
- Pulse `done_trans` during EDGE → ignored.
- Assert `reset` at T+5 → all outputs 0, no `done_comb`; a subsequent run produces correct sums.
